// File: rtl/gray_ptr_ctrl_if.sv
// Pointer-controller bus: increment handshake, remote Gray pointer in,
// local pointer images and occupancy status out.
interface gray_ptr_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    localparam int unsigned PW = ADDR_W + 1;

    logic              inc_req;
    logic              inc_ack;
    logic [PW-1:0]     remote_gray;
    logic [PW-1:0]     ptr_bin;
    logic [PW-1:0]     ptr_gray;
    logic [ADDR_W-1:0] addr;
    logic              flag;
    logic [PW-1:0]     level;
    logic              err;

    modport master (
        output inc_req, remote_gray,
        input  inc_ack, ptr_bin, ptr_gray, addr, flag, level, err
    );

    modport slave (
        input  inc_req, remote_gray,
        output inc_ack, ptr_bin, ptr_gray, addr, flag, level, err
    );
endinterface

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO pointer path: local binary/Gray pointer,
// remote Gray decode, and registered full (write) or empty (read) flag.
module gray_ptr_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned MODE   = 0
) (
    input logic           clk,
    input logic           rst,
    gray_ptr_ctrl_if.slave bus
);
    localparam int unsigned   PW        = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH     = PW'(1) << ADDR_W;
    localparam bit            READ_SIDE = (MODE == 1);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] ptr_bin_q;
    logic [PW-1:0] ptr_gray_q;
    logic [PW-1:0] level_q;
    logic          flag_q;
    logic          err_q;

    logic          inc_ack_c;
    logic [PW-1:0] ptr_bin_next;
    logic [PW-1:0] remote_bin_next;
    logic [PW-1:0] level_next;
    logic          flag_next;
    logic          err_set;

    // Next-state pointer and occupancy; local and remote moves combine freely.
    always_comb begin
        inc_ack_c       = bus.inc_req & ~flag_q;
        ptr_bin_next    = ptr_bin_q + PW'(inc_ack_c);
        remote_bin_next = gray2bin(bus.remote_gray);
        level_next      = ptr_bin_next - remote_bin_next;
        flag_next       = 1'b0;
        if (READ_SIDE) begin
            level_next = remote_bin_next - ptr_bin_next;
            flag_next  = (level_next == '0);
        end else begin
            flag_next  = (level_next == DEPTH);
        end
        err_set = (level_next > DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin_q  <= '0;
            ptr_gray_q <= '0;
            level_q    <= '0;
            flag_q     <= READ_SIDE;
            err_q      <= 1'b0;
        end else begin
            ptr_bin_q  <= ptr_bin_next;
            ptr_gray_q <= bin2gray(ptr_bin_next);
            level_q    <= level_next;
            flag_q     <= flag_next;
            err_q      <= err_q | err_set;
        end
    end

    assign bus.inc_ack  = inc_ack_c;
    assign bus.ptr_bin  = ptr_bin_q;
    assign bus.ptr_gray = ptr_gray_q;
    assign bus.addr     = ptr_bin_q[ADDR_W-1:0];
    assign bus.flag     = flag_q;
    assign bus.level    = level_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_gray_ptr_ctrl.sv
// Directed bench for gray_ptr_ctrl: a write-side and a read-side instance
// sharing one clock, each with its own reset.
module tb_gray_ptr_ctrl;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    gray_ptr_ctrl_if #(.ADDR_W(4)) bus0 ();
    gray_ptr_ctrl_if #(.ADDR_W(4)) bus1 ();

    gray_ptr_ctrl #(.ADDR_W(4), .MODE(0)) dut_wr (.clk(clk), .rst(rst0), .bus(bus0));
    gray_ptr_ctrl #(.ADDR_W(4), .MODE(1)) dut_rd (.clk(clk), .rst(rst1), .bus(bus1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_wr();
        rst0 = 1'b1; bus0.inc_req = 1'b0; bus0.remote_gray = 5'd0;
        step(); step();
        rst0 = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.inc_req = 1'b1; bus0.remote_gray = 5'b10110;
        bus1.inc_req = 1'b1; bus1.remote_gray = 5'b01011;
        step(); step();
        checks++; if (bus0.ptr_bin !== 5'd0) begin failures++; $display("FAIL reset_wr_ptr_bin got=%0d exp=0", bus0.ptr_bin); end
        checks++; if (bus0.ptr_gray !== 5'd0) begin failures++; $display("FAIL reset_wr_ptr_gray got=%0d exp=0", bus0.ptr_gray); end
        checks++; if (bus0.level !== 5'd0) begin failures++; $display("FAIL reset_wr_level got=%0d exp=0", bus0.level); end
        checks++; if (bus0.err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%0b exp=0", bus0.err); end
        checks++; if (bus0.flag !== 1'b0) begin failures++; $display("FAIL reset_wr_flag got=%0b exp=0", bus0.flag); end
        checks++; if (bus1.ptr_bin !== 5'd0) begin failures++; $display("FAIL reset_rd_ptr_bin got=%0d exp=0", bus1.ptr_bin); end
        checks++; if (bus1.level !== 5'd0) begin failures++; $display("FAIL reset_rd_level got=%0d exp=0", bus1.level); end
        checks++; if (bus1.flag !== 1'b1) begin failures++; $display("FAIL reset_rd_flag got=%0b exp=1", bus1.flag); end
        checks++; if (bus1.err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%0b exp=0", bus1.err); end
        bus0.inc_req = 1'b0; bus0.remote_gray = 5'd0;
        bus1.inc_req = 1'b0; bus1.remote_gray = 5'd0;
        step();
        rst0 = 1'b0; rst1 = 1'b0;
    endtask

    task automatic test_fill();
        int acks = 0;
        int exp_ptr;
        reset_wr();
        bus0.inc_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus0.inc_ack === 1'b1) acks++;
            step();
            exp_ptr = (i + 1 < 16) ? i + 1 : 16;
            checks++; if (bus0.ptr_bin !== 5'(exp_ptr)) begin failures++; $display("FAIL fill_ptr_step%0d got=%0d exp=%0d", i, bus0.ptr_bin, exp_ptr); end
        end
        checks++; if (acks != 16) begin failures++; $display("FAIL fill_ack_count got=%0d exp=16", acks); end
        checks++; if (bus0.flag !== 1'b1) begin failures++; $display("FAIL fill_flag got=%0b exp=1", bus0.flag); end
        checks++; if (bus0.level !== 5'd16) begin failures++; $display("FAIL fill_level got=%0d exp=16", bus0.level); end
        checks++; if (bus0.ptr_gray !== 5'b11000) begin failures++; $display("FAIL fill_ptr_gray got=%b exp=11000", bus0.ptr_gray); end
        checks++; if (bus0.addr !== 4'd0) begin failures++; $display("FAIL fill_addr got=%0d exp=0", bus0.addr); end
        checks++; if (bus0.inc_ack !== 1'b0) begin failures++; $display("FAIL fill_inc_ack got=%0b exp=0", bus0.inc_ack); end
        bus0.inc_req = 1'b0;
    endtask

    task automatic test_gray_wrap();
        logic [4:0] p = 5'd0;
        logic [4:0] prev_gray = 5'd0;
        logic [4:0] exp_gray;
        reset_wr();
        for (int k = 0; k < 40; k++) begin
            bus0.remote_gray = p ^ (p >> 1);
            bus0.inc_req = 1'b1;
            step();
            p = p + 5'd1;
            exp_gray = p ^ (p >> 1);
            checks++; if (bus0.ptr_bin !== p) begin failures++; $display("FAIL wrap_ptr_bin step%0d got=%0d exp=%0d", k, bus0.ptr_bin, p); end
            checks++; if (bus0.ptr_gray !== exp_gray) begin failures++; $display("FAIL wrap_ptr_gray step%0d got=%b exp=%b", k, bus0.ptr_gray, exp_gray); end
            checks++; if ($countones(bus0.ptr_gray ^ prev_gray) != 1) begin failures++; $display("FAIL wrap_one_bit step%0d got=%b prev=%b", k, bus0.ptr_gray, prev_gray); end
            checks++; if (bus0.level !== 5'd1 || bus0.flag !== 1'b0) begin failures++; $display("FAIL wrap_level step%0d got=%0d/%0b exp=1/0", k, bus0.level, bus0.flag); end
            if (p == 5'd31) begin
                checks++; if (bus0.ptr_gray !== 5'b10000) begin failures++; $display("FAIL wrap_gray31 got=%b exp=10000", bus0.ptr_gray); end
            end
            if (p == 5'd0) begin
                checks++; if (bus0.ptr_gray !== 5'b00000 || bus0.ptr_bin !== 5'd0) begin failures++; $display("FAIL wrap_zero got=%0d/%b exp=0/00000", bus0.ptr_bin, bus0.ptr_gray); end
            end
            prev_gray = bus0.ptr_gray;
        end
        bus0.inc_req = 1'b0;
    endtask

    task automatic test_read_latency();
        rst1 = 1'b1; bus1.inc_req = 1'b0; bus1.remote_gray = 5'd0;
        step(); step();
        rst1 = 1'b0;
        bus1.inc_req = 1'b1;
        #1;
        checks++; if (bus1.inc_ack !== 1'b0) begin failures++; $display("FAIL rd_empty_ack got=%0b exp=0", bus1.inc_ack); end
        bus1.inc_req = 1'b0;
        bus1.remote_gray = 5'b00010;
        step();
        checks++; if (bus1.flag !== 1'b0) begin failures++; $display("FAIL rd_latency_flag got=%0b exp=0", bus1.flag); end
        checks++; if (bus1.level !== 5'd3) begin failures++; $display("FAIL rd_latency_level got=%0d exp=3", bus1.level); end
        bus1.inc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus1.inc_ack !== 1'b1) begin failures++; $display("FAIL rd_ack%0d got=%0b exp=1", i, bus1.inc_ack); end
            step();
        end
        checks++; if (bus1.flag !== 1'b1) begin failures++; $display("FAIL rd_drain_flag got=%0b exp=1", bus1.flag); end
        checks++; if (bus1.level !== 5'd0) begin failures++; $display("FAIL rd_drain_level got=%0d exp=0", bus1.level); end
        checks++; if (bus1.ptr_bin !== 5'd3) begin failures++; $display("FAIL rd_drain_ptr got=%0d exp=3", bus1.ptr_bin); end
        checks++; if (bus1.inc_ack !== 1'b0) begin failures++; $display("FAIL rd_fourth_ack got=%0b exp=0", bus1.inc_ack); end
        step();
        checks++; if (bus1.ptr_bin !== 5'd3) begin failures++; $display("FAIL rd_hold_ptr got=%0d exp=3", bus1.ptr_bin); end
        bus1.inc_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        reset_wr();
        bus0.inc_req = 1'b1;
        for (int i = 0; i < 15; i++) step();
        checks++; if (bus0.level !== 5'd15 || bus0.flag !== 1'b0) begin failures++; $display("FAIL simul_pre got=%0d/%0b exp=15/0", bus0.level, bus0.flag); end
        bus0.remote_gray = 5'b00001;
        #1;
        checks++; if (bus0.inc_ack !== 1'b1) begin failures++; $display("FAIL simul_ack got=%0b exp=1", bus0.inc_ack); end
        step();
        checks++; if (bus0.level !== 5'd15) begin failures++; $display("FAIL simul_level got=%0d exp=15", bus0.level); end
        checks++; if (bus0.flag !== 1'b0) begin failures++; $display("FAIL simul_flag got=%0b exp=0", bus0.flag); end
        checks++; if (bus0.ptr_bin !== 5'd16) begin failures++; $display("FAIL simul_ptr got=%0d exp=16", bus0.ptr_bin); end
        bus0.inc_req = 1'b0;
    endtask

    task automatic test_corruption();
        reset_wr();
        bus0.remote_gray = 5'b01100;
        step();
        checks++; if (bus0.err !== 1'b1) begin failures++; $display("FAIL corrupt_err got=%0b exp=1", bus0.err); end
        checks++; if (bus0.level !== 5'd24 || bus0.flag !== 1'b0) begin failures++; $display("FAIL corrupt_level got=%0d/%0b exp=24/0", bus0.level, bus0.flag); end
        bus0.remote_gray = 5'd0;
        bus0.inc_req = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus0.err !== 1'b1) begin failures++; $display("FAIL corrupt_sticky got=%0b exp=1", bus0.err); end
        checks++; if (bus0.level !== 5'd5 || bus0.ptr_bin !== 5'd5) begin failures++; $display("FAIL corrupt_fill got=%0d/%0d exp=5/5", bus0.level, bus0.ptr_bin); end
        rst0 = 1'b1;
        step();
        checks++; if (bus0.ptr_bin !== 5'd0 || bus0.ptr_gray !== 5'd0) begin failures++; $display("FAIL midrst_ptr got=%0d/%0d exp=0/0", bus0.ptr_bin, bus0.ptr_gray); end
        checks++; if (bus0.level !== 5'd0 || bus0.flag !== 1'b0) begin failures++; $display("FAIL midrst_level got=%0d/%0b exp=0/0", bus0.level, bus0.flag); end
        checks++; if (bus0.err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%0b exp=0", bus0.err); end
        rst0 = 1'b0;
        bus0.inc_req = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.inc_req = 1'b0; bus0.remote_gray = 5'd0;
        bus1.inc_req = 1'b0; bus1.remote_gray = 5'd0;
        #1;
        test_reset();
        test_fill();
        test_gray_wrap();
        test_read_latency();
        test_simultaneous();
        test_corruption();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
